rf_multiport: RTL and testbench
===============================

Name: rf_multiport

Overview:
- Parametrised general-purpose register file for the pipelined core; successor to the single-write, two-read RF.
- Adds:
  - configurable data width, depth and read-port count
  - two write ports with fixed priority
  - optional write-to-read bypass
  - hardware-zero register
  - asynchronous clear
  - a per-register pending scoreboard used by the hazard unit to stall issue
- Sits between decode/issue (read and issue ports) and writeback (write ports).

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register index width; depth = 2**ADDR_W.
- NUM_RD, 2, number of read ports (1..4).
- ZERO_REG, 1, 1 = index 0 reads 0, ignores writes and is never pending.
- BYPASS, 1, 1 = same-cycle write data is forwarded to matching read ports.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- we0  in  1  write enable, port 0 (ALU writeback).
- wa0  in  ADDR_W  write address, port 0.
- wd0  in  DATA_W  write data, port 0.
- we1  in  1  write enable, port 1 (load writeback; higher priority).
- wa1  in  ADDR_W  write address, port 1.
- wd1  in  DATA_W  write data, port 1.
- ra  in  NUM_RD*ADDR_W  read addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
- rd  out  NUM_RD*DATA_W  read data; port i occupies bits [i*DATA_W +: DATA_W].
- busy  out  NUM_RD  busy[i] = register ra[i] has an outstanding producer.
- iss_valid  in  1  issue of an instruction that will write iss_addr.
- iss_addr  in  ADDR_W  destination of the issuing instruction.
- dbg_addr  in  ADDR_W  debug read address.
- dbg_data  out  DATA_W  raw array contents at dbg_addr (no bypass).

Behaviour:
- Clock and reset:
  - One clock, clk. Reset rst_n is asynchronous, active-low.
  - Assertion immediately clears all registers and all pending bits.
  - While rst_n=0: rd, dbg_data and busy read 0, all writes and issues are ignored.
  - Deassertion is synchronised by the top level; the block takes no special action on it.
- Writes, at the clk edge:
  - wex=1 writes wdx to register wax.
  - When we0=we1=1 and wa0==wa1, port 1 data is stored; port 0 is dropped.
  - With ZERO_REG=1, writes to index 0 are discarded.
- Reads:
  - Combinational, 0-cycle latency.
  - With ZERO_REG=1, ra[i]==0 returns 0 regardless of bypass.
  - With BYPASS=1, ra[i] matching an active write forwards that write data; port 1 beats port 0.
  - With BYPASS=0, reads return the array value, i.e. old data in the write cycle and new data from the next cycle.
- Scoreboard: pending[2**ADDR_W] flags, updated at clk:
  - Set: iss_valid=1 sets pending[iss_addr].
  - Clear: each active write clears pending[wax].
  - Simultaneous set and clear on the same index: set wins, because a new producer was issued.
  - With ZERO_REG=1, pending[0] is hardwired 0.
  - Re-issue to an already-pending index: stays 1; there is no counting.
- busy:
  - busy[i] = pending[ra[i]].
  - With BYPASS=1, busy[i] is forced to 0 when a write to ra[i] is active in the same cycle, since the data is available via the bypass.
  - With BYPASS=0, busy[i] stays 1 in that cycle and drops the next cycle.
- Port independence:
  - Read ports are independent; any number may alias the same index.
  - dbg_data is never bypassed and never affected by the ZERO_REG read override beyond the stored value, which is always 0 for index 0.
- Width rules: no arithmetic. Addresses are used unsigned; all indices are in range by construction.

Test Plan:
- Reset mid-run:
  - Stimulus: write x5=0xDEADBEEF, issue x7, then pulse rst_n low for 3 ns between edges.
  - Response: rd for x5 = 0 immediately and busy for x7 = 0 immediately, with no clock edge needed.
- Dual-write collision:
  - Stimulus: we0=we1=1, wa0=wa1=3, wd0=0x11, wd1=0x22.
  - Response: next cycle ra0=3 reads 0x22.
  - Also with BYPASS=1: the same cycle reads 0x22.
- Zero register:
  - Stimulus: we1=1, wa1=0, wd1=0xFFFFFFFF, plus iss_valid to index 0.
  - Response: ra0=0 reads 0 in the same and next cycle, busy[0]=0, and dbg_data at index 0 = 0.
- Bypass vs no-bypass:
  - Stimulus: in the write cycle, wa0=9, wd0=0xCAFE0001, ra1=9.
  - Response: rd port 1 = 0xCAFE0001 with BYPASS=1, or the prior value with BYPASS=0; both configurations read 0xCAFE0001 the next cycle.
- Scoreboard:
  - Stimulus: issue x4, then 2 idle cycles with ra0=4, then write x4 while re-issuing x4.
  - Response: busy[0]=1 during the idle cycles and stays 1 after the simultaneous set/clear.
  - Then a plain write to x4 gives busy[0]=0 next cycle, and 0 in the same cycle with BYPASS=1.
- Parameter sweep:
  - Stimulus: DATA_W=64, ADDR_W=4, NUM_RD=3; fill all 16 registers with index*0x0101010101010101, reading all 3 ports at distinct and aliased addresses.
  - Response: all reads match, except index 0, which reads 0.

Source files
------------

// File: rtl/rf_multiport.sv
// Multi-port general-purpose register file with two prioritised write ports, optional
// write-to-read bypass, hardware-zero register and a per-register pending scoreboard.
module rf_multiport #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       we0,
    input  logic [ADDR_W-1:0]          wa0,
    input  logic [DATA_W-1:0]          wd0,
    input  logic                       we1,
    input  logic [ADDR_W-1:0]          wa1,
    input  logic [DATA_W-1:0]          wd1,
    input  logic [NUM_RD*ADDR_W-1:0]   ra,
    output logic [NUM_RD*DATA_W-1:0]   rd,
    output logic [NUM_RD-1:0]          busy,
    input  logic                       iss_valid,
    input  logic [ADDR_W-1:0]          iss_addr,
    input  logic [ADDR_W-1:0]          dbg_addr,
    output logic [DATA_W-1:0]          dbg_data
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  pend_q;
    logic [DEPTH-1:0]  pend_d;

    logic w0_en;
    logic w1_en;

    assign w0_en = we0 && !((ZERO_REG != 0) && (wa0 == '0));
    assign w1_en = we1 && !((ZERO_REG != 0) && (wa1 == '0));

    // Port 1 is applied last so it wins an address collision.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (w0_en) begin
            mem_d[wa0] = wd0;
        end
        if (w1_en) begin
            mem_d[wa1] = wd1;
        end
    end

    // Set is applied after clear: a newly issued producer outranks a completing one.
    always_comb begin
        pend_d = pend_q;
        if (w0_en) begin
            pend_d[wa0] = 1'b0;
        end
        if (w1_en) begin
            pend_d[wa1] = 1'b0;
        end
        if (iss_valid) begin
            pend_d[iss_addr] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            pend_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            pend_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            pend_q <= pend_d;
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              bsy;

        assign addr = ra[g*ADDR_W +: ADDR_W];

        always_comb begin
            data = mem_q[addr];
            bsy  = pend_q[addr];
            if (BYPASS != 0) begin
                if (we0 && (wa0 == addr)) begin
                    data = wd0;
                    bsy  = 1'b0;
                end
                if (we1 && (wa1 == addr)) begin
                    data = wd1;
                    bsy  = 1'b0;
                end
            end
            if ((ZERO_REG != 0) && (addr == '0)) begin
                data = '0;
                bsy  = 1'b0;
            end
            if (!rst_n) begin
                data = '0;
                bsy  = 1'b0;
            end
        end

        assign rd[g*DATA_W +: DATA_W] = data;
        assign busy[g]                = bsy;
    end

    assign dbg_data = rst_n ? mem_q[dbg_addr] : '0;

endmodule

// File: tb/tb_rf_multiport.sv
// Scoreboard bench for rf_multiport: bypass and no-bypass instances share stimulus,
// plus a 64-bit/16-entry/3-port instance for the parameter sweep.
module tb_rf_multiport;

    typedef struct {
        int          cyc;
        int          inst;
        int          kind;   // 0 rd, 1 busy, 2 dbg_data
        int          port;
        logic [63:0] exp;
        string       name;
    } exp_t;

    exp_t q[$];
    int   cyc     = 0;
    int   npass   = 0;
    int   ntotal  = 0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic        we0 = 0, we1 = 0, iss_valid = 0;
    logic [4:0]  wa0 = 0, wa1 = 0, iss_addr = 0, dbg_addr = 0;
    logic [31:0] wd0 = 0, wd1 = 0;
    logic [9:0]  ra = 0;
    logic [63:0] a_rd, b_rd;
    logic [1:0]  a_busy, b_busy;
    logic [31:0] a_dbg, b_dbg;

    logic        c_we0 = 0, c_we1 = 0;
    logic [3:0]  c_wa0 = 0, c_wa1 = 0, c_dbg_addr = 0;
    logic [63:0] c_wd0 = 0, c_wd1 = 0, c_dbg;
    logic [11:0] c_ra = 0;
    logic [191:0] c_rd;
    logic [2:0]  c_busy;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rf_multiport #(.BYPASS(1)) u_a (
        .clk(clk), .rst_n(rst_n), .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1),
        .wd1(wd1), .ra(ra), .rd(a_rd), .busy(a_busy), .iss_valid(iss_valid),
        .iss_addr(iss_addr), .dbg_addr(dbg_addr), .dbg_data(a_dbg)
    );

    rf_multiport #(.BYPASS(0)) u_b (
        .clk(clk), .rst_n(rst_n), .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1),
        .wd1(wd1), .ra(ra), .rd(b_rd), .busy(b_busy), .iss_valid(iss_valid),
        .iss_addr(iss_addr), .dbg_addr(dbg_addr), .dbg_data(b_dbg)
    );

    rf_multiport #(.DATA_W(64), .ADDR_W(4), .NUM_RD(3)) u_c (
        .clk(clk), .rst_n(rst_n), .we0(c_we0), .wa0(c_wa0), .wd0(c_wd0), .we1(c_we1),
        .wa1(c_wa1), .wd1(c_wd1), .ra(c_ra), .rd(c_rd), .busy(c_busy), .iss_valid(1'b0),
        .iss_addr(4'd0), .dbg_addr(c_dbg_addr), .dbg_data(c_dbg)
    );

    function automatic logic [63:0] get(int inst, int kind, int port);
        case (inst)
            0: case (kind)
                0:       return {32'd0, a_rd[port*32 +: 32]};
                1:       return {63'd0, a_busy[port]};
                default: return {32'd0, a_dbg};
            endcase
            1: case (kind)
                0:       return {32'd0, b_rd[port*32 +: 32]};
                1:       return {63'd0, b_busy[port]};
                default: return {32'd0, b_dbg};
            endcase
            default: case (kind)
                0:       return c_rd[port*64 +: 64];
                1:       return {63'd0, c_busy[port]};
                default: return c_dbg;
            endcase
        endcase
    endfunction

    // Monitor: compares every expectation registered for the current cycle mid-cycle.
    initial begin
        exp_t        e;
        logic [63:0] act;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e   = q.pop_front();
                act = get(e.inst, e.kind, e.port);
                ntotal++;
                if (act === e.exp) npass++;
                else $display("FAIL %s (inst %0d port %0d): got %h, expected %h",
                              e.name, e.inst, e.port, act, e.exp);
            end
        end
    end

    task automatic push(string name, int inst, int kind, int port, logic [63:0] ev);
        exp_t e;
        e.cyc = cyc; e.inst = inst; e.kind = kind; e.port = port; e.exp = ev; e.name = name;
        q.push_back(e);
    endtask

    task automatic push_ab(string name, int kind, int port, logic [63:0] ea, logic [63:0] eb);
        push(name, 0, kind, port, ea);
        push(name, 1, kind, port, eb);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we0 = 0; we1 = 0; iss_valid = 0;
        c_we0 = 0; c_we1 = 0;
    endtask

    initial begin
        logic [63:0] pat;
        logic [3:0]  p [3];
        pat = 64'h0101010101010101;

        tick(); tick();
        rst_n = 1'b1;

        // Reset state
        ra = {5'd7, 5'd5}; dbg_addr = 5'd5;
        push_ab("reset_rd", 0, 0, 0, 0);
        push_ab("reset_busy", 1, 1, 0, 0);
        push_ab("reset_dbg", 2, 0, 0, 0);
        tick();

        // Dual-write collision
        we0 = 1; wa0 = 3; wd0 = 32'h11; we1 = 1; wa1 = 3; wd1 = 32'h22; ra = {5'd0, 5'd3};
        push_ab("collide_same", 0, 0, 32'h22, 0);
        tick(); idle();
        push_ab("collide_next", 0, 0, 32'h22, 32'h22);
        tick();

        // Zero register
        we1 = 1; wa1 = 0; wd1 = 32'hFFFFFFFF; iss_valid = 1; iss_addr = 0;
        ra = {5'd0, 5'd0}; dbg_addr = 0;
        push_ab("zero_same", 0, 0, 0, 0);
        tick(); idle();
        push_ab("zero_next", 0, 0, 0, 0);
        push_ab("zero_busy", 1, 0, 0, 0);
        push_ab("zero_dbg", 2, 0, 0, 0);
        tick();

        // Bypass vs no-bypass
        we0 = 1; wa0 = 9; wd0 = 32'h12345678;
        tick(); idle();
        we0 = 1; wa0 = 9; wd0 = 32'hCAFE0001; ra = {5'd9, 5'd0}; dbg_addr = 9;
        push_ab("bypass_same", 0, 1, 32'hCAFE0001, 32'h12345678);
        push_ab("bypass_dbg_raw", 2, 0, 32'h12345678, 32'h12345678);
        tick(); idle();
        push_ab("bypass_next", 0, 1, 32'hCAFE0001, 32'hCAFE0001);
        push_ab("bypass_dbg_next", 2, 0, 32'hCAFE0001, 32'hCAFE0001);
        tick();

        // Scoreboard
        iss_valid = 1; iss_addr = 4; ra = {5'd0, 5'd4};
        push_ab("sb_issue_cycle", 1, 0, 0, 0);
        tick(); idle();
        push_ab("sb_idle1", 1, 0, 1, 1);
        tick();
        push_ab("sb_idle2", 1, 0, 1, 1);
        tick();
        we0 = 1; wa0 = 4; wd0 = 32'h44; iss_valid = 1; iss_addr = 4;
        push_ab("sb_setclr_same", 1, 0, 0, 1);
        tick(); idle();
        push_ab("sb_setclr_after", 1, 0, 1, 1);
        push_ab("sb_setclr_data", 0, 0, 32'h44, 32'h44);
        tick();
        we0 = 1; wa0 = 4; wd0 = 32'h45;
        push_ab("sb_write_same", 1, 0, 0, 1);
        tick(); idle();
        push_ab("sb_write_next", 1, 0, 0, 0);
        push_ab("sb_write_data", 0, 0, 32'h45, 32'h45);
        tick();

        // Reset mid-run
        we0 = 1; wa0 = 5; wd0 = 32'hDEADBEEF; iss_valid = 1; iss_addr = 7;
        tick(); idle();
        ra = {5'd7, 5'd5};
        push_ab("pre_reset_rd", 0, 0, 32'hDEADBEEF, 32'hDEADBEEF);
        push_ab("pre_reset_busy", 1, 1, 1, 1);
        tick();
        push_ab("in_reset_rd", 0, 0, 0, 0);
        push_ab("in_reset_busy", 1, 1, 0, 0);
        #3 rst_n = 1'b0; we0 = 1; wa0 = 5; wd0 = 32'h1;
        #1;
        ntotal++;
        if (a_rd[31:0] === 32'd0) npass++;
        else $display("FAIL async_reset_rd (inst 0): got %h", a_rd[31:0]);
        ntotal++;
        if (b_rd[31:0] === 32'd0) npass++;
        else $display("FAIL async_reset_rd (inst 1): got %h", b_rd[31:0]);
        ntotal++;
        if (a_busy[1] === 1'b0) npass++;
        else $display("FAIL async_reset_busy (inst 0): got %b", a_busy[1]);
        ntotal++;
        if (b_busy[1] === 1'b0) npass++;
        else $display("FAIL async_reset_busy (inst 1): got %b", b_busy[1]);
        ntotal++;
        if (a_dbg === 32'd0) npass++;
        else $display("FAIL async_reset_dbg (inst 0): got %h", a_dbg);
        ntotal++;
        if (b_dbg === 32'd0) npass++;
        else $display("FAIL async_reset_dbg (inst 1): got %h", b_dbg);
        #2 rst_n = 1'b1; we0 = 0;
        tick();
        push_ab("post_reset_rd", 0, 0, 0, 0);
        push_ab("post_reset_busy", 1, 1, 0, 0);
        tick();

        // Parameter sweep on the 64-bit, 16-entry, 3-port instance
        for (int i = 0; i < 16; i += 2) begin
            c_we0 = 1; c_wa0 = 4'(i);     c_wd0 = 64'(i) * pat;
            c_we1 = 1; c_wa1 = 4'(i + 1); c_wd1 = 64'(i + 1) * pat;
            tick();
        end
        idle();
        for (int i = 0; i < 16; i++) begin
            p[0] = 4'(i); p[1] = 4'((i + 5) % 16); p[2] = 4'(i);
            c_ra = {p[2], p[1], p[0]};
            for (int k = 0; k < 3; k++)
                push("sweep_rd", 2, 0, k, (p[k] == 0) ? 64'd0 : 64'(p[k]) * pat);
            tick();
        end
        c_dbg_addr = 4'd15;
        push("sweep_dbg", 2, 2, 0, 64'h0F0F0F0F0F0F0F0F);
        tick(); tick(); tick();

        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            ntotal++;
            $display("FAIL %s: never compared, expected %h", e.name, e.exp);
        end
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
